// File: rtl/hsi_vec_pkg.sv
// hsi_vec_pkg: shared op encoding, full-precision vector type and component fit helpers
// Macro HSI_VECTOR_UNIT_SAT_EN: when defined, overflowing components clamp; otherwise they wrap.
package hsi_vec_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_CROSS = 2'd1, OP_DOT = 2'd2, OP_SUB = 2'd3} hsi_op_t;
  // Wide enough for a three-term sum of 2W-bit products for any W up to 35.
  localparam int FULL_W = 72;
  typedef struct packed {
    logic [FULL_W-1:0] x;
    logic [FULL_W-1:0] y;
    logic [FULL_W-1:0] z;
  } hsi_vec_t;
  function automatic logic comp_ovf(input logic signed [FULL_W-1:0] v, input int w);
    logic signed [FULL_W-1:0] hi;
    hi = (FULL_W'(1) << (w - 1)) - FULL_W'(1);
    // ~hi is the most negative w-bit value
    return v > hi || v < ~hi;
  endfunction
  function automatic logic signed [FULL_W-1:0] fit_comp(input logic signed [FULL_W-1:0] v, input int w);
    logic signed [FULL_W-1:0] hi;
`ifdef HSI_VECTOR_UNIT_SAT_EN
    hi = (FULL_W'(1) << (w - 1)) - FULL_W'(1);
    return v > hi ? hi : v < ~hi ? ~hi : v;
`else
    hi = (FULL_W'(1) << w) - FULL_W'(1);
    return v & hi;
`endif
  endfunction
endpackage

// File: rtl/fifo_cache.sv
// fifo_cache: synchronous FIFO with registered read data (valid the cycle after rd_en_i)
// Ports: wr_en_i/data_i push (ignored when full), rd_en_i pops (ignored when empty),
//        data_o registered head, empty_o/full_o status; async active-low reset empties it.
module fifo_cache #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic [WIDTH-1:0] data_q;
  logic wr, rd;
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign wr = wr_en_i && !full_o;
  assign rd = rd_en_i && !empty_o;
  assign data_o = data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      data_q <= '0;
    end else begin
      wp_q <= wp_q + (AW+1)'(wr);
      rp_q <= rp_q + (AW+1)'(rd);
      if (rd) data_q <= mem_q[rp_q[AW-1:0]];
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/hsi_vec_alu.sv
// hsi_vec_alu: three-stage vector arithmetic pipeline (S1 capture, S2 products/sums, S3 combine+fit)
// Ports: issue_i/op_i sampled at issue, a_i/b_i operands valid in the S1 cycle,
//        valid_o/data_o/ovf_o S3 result, busy_o any stage valid.
// Macro HSI_VECTOR_UNIT_SAT_EN selects clamping in fit_comp.
module hsi_vec_alu
  import hsi_vec_pkg::*;
#(
  parameter int W = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           issue_i,
  input  hsi_op_t        op_i,
  input  logic [3*W-1:0] a_i,
  input  logic [3*W-1:0] b_i,
  output logic           valid_o,
  output logic [3*W-1:0] data_o,
  output logic           ovf_o,
  output logic           busy_o
);
  localparam int PW = 2 * W;
  logic v1_q, v2_q, v3_q;
  hsi_op_t op1_q, op2_q;
  logic signed [PW-1:0] ea1, eb1, ec1, ea2, eb2, ec2;
  logic signed [PW-1:0] p_d [6];
  logic signed [PW-1:0] p_q [6];
  logic signed [FULL_W-1:0] q [6];
  logic signed [FULL_W-1:0] cx, cy, cz, dx;
  hsi_vec_t f;
  logic [3*W-1:0] r_d, r_q;
  logic ovf_d, ovf_q;
  logic cr1, dt1, ad1, cr2, dt2;
  assign ea1 = PW'($signed(a_i[3*W-1 -: W]));
  assign eb1 = PW'($signed(a_i[2*W-1 -: W]));
  assign ec1 = PW'($signed(a_i[W-1:0]));
  assign ea2 = PW'($signed(b_i[3*W-1 -: W]));
  assign eb2 = PW'($signed(b_i[2*W-1 -: W]));
  assign ec2 = PW'($signed(b_i[W-1:0]));
  assign cr1 = op1_q == OP_CROSS;
  assign dt1 = op1_q == OP_DOT;
  assign ad1 = op1_q == OP_ADD;
  assign cr2 = op2_q == OP_CROSS;
  assign dt2 = op2_q == OP_DOT;
  // Terms 0..2 double as DOT products and ADD/SUB sums; terms 3..5 only matter for CROSS.
  always_comb begin
    p_d[0] = cr1 ? eb1 * ec2 : dt1 ? ea1 * ea2 : ad1 ? ea1 + ea2 : ea1 - ea2;
    p_d[1] = cr1 ? ec1 * eb2 : dt1 ? eb1 * eb2 : ad1 ? eb1 + eb2 : eb1 - eb2;
    p_d[2] = cr1 ? ec1 * ea2 : dt1 ? ec1 * ec2 : ad1 ? ec1 + ec2 : ec1 - ec2;
    p_d[3] = cr1 ? ea1 * ec2 : '0;
    p_d[4] = cr1 ? ea1 * eb2 : '0;
    p_d[5] = cr1 ? eb1 * ea2 : '0;
  end
  always_comb begin
    for (int i = 0; i < 6; i++) q[i] = FULL_W'(p_q[i]);
    cx = (q[0] - q[1]) >>> FRAC_BITS;
    cy = (q[2] - q[3]) >>> FRAC_BITS;
    cz = (q[4] - q[5]) >>> FRAC_BITS;
    dx = (q[0] + q[1] + q[2]) >>> FRAC_BITS;
    f.x = cr2 ? cx : dt2 ? dx : q[0];
    f.y = cr2 ? cy : dt2 ? '0 : q[1];
    f.z = cr2 ? cz : dt2 ? '0 : q[2];
    r_d = {W'(fit_comp(f.x, W)), W'(fit_comp(f.y, W)), W'(fit_comp(f.z, W))};
    ovf_d = comp_ovf(f.x, W) || comp_ovf(f.y, W) || comp_ovf(f.z, W);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= issue_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  always_ff @(posedge clk) begin
    if (issue_i) op1_q <= op_i;
    op2_q <= op1_q;
    p_q <= p_d;
    r_q <= r_d;
    ovf_q <= ovf_d;
  end
  assign valid_o = v3_q;
  assign data_o = r_q;
  assign ovf_o = ovf_q;
  assign busy_o = v1_q || v2_q || v3_q;
endmodule

// File: rtl/hsi_vector_unit.sv
// hsi_vector_unit: FIFO-fed HSI vector engine (ADD/CROSS/DOT/SUB) with credit backpressure
// Ports: in1_/in2_ operand FIFO pushes and full flags; out_ result FIFO pop, data, empty/full;
//        op_code sampled at issue; ovf_clr/ovf_flag sticky overflow; busy; result_count.
// Macro HSI_VECTOR_UNIT_SAT_EN: clamp overflowing components instead of wrapping.
module hsi_vector_unit
  import hsi_vec_pkg::*;
#(
  parameter int COMPONENT_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int OPC_WIDTH = 2,
  parameter int FRAC_BITS = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in1_wr_en,
  input  logic [3*COMPONENT_WIDTH-1:0] in1_data_in,
  output logic                         in1_full,
  input  logic                         in2_wr_en,
  input  logic [3*COMPONENT_WIDTH-1:0] in2_data_in,
  output logic                         in2_full,
  input  logic                         out_rd_en,
  output logic [3*COMPONENT_WIDTH-1:0] out_data_out,
  output logic                         out_empty,
  output logic                         out_full,
  input  logic [OPC_WIDTH-1:0]         op_code,
  input  logic                         ovf_clr,
  output logic                         ovf_flag,
  output logic                         busy,
  output logic [15:0]                  result_count
);
  localparam int DW = 3 * COMPONENT_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic in1_empty, in2_empty, issue, out_pop, out_wr_en, alu_ovf;
  logic [DW-1:0] a_data, b_data, alu_data;
  logic [CW-1:0] credits_q, credits_d;
  logic ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  // One credit per free output FIFO slot guarantees every issued pair has room when it lands.
  assign issue = !in1_empty && !in2_empty && credits_q != '0;
  assign out_pop = out_rd_en && !out_empty;
  always_comb begin
    credits_d = credits_q + CW'(out_pop) - CW'(issue);
    ovf_d = (out_wr_en && alu_ovf) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    cnt_d = cnt_q + 16'(out_wr_en);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credits_q <= CW'(FIFO_DEPTH);
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      credits_q <= credits_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  fifo_cache #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_in1 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(in1_wr_en), .data_i(in1_data_in), .rd_en_i(issue),
    .data_o(a_data), .empty_o(in1_empty), .full_o(in1_full)
  );
  fifo_cache #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_in2 (
    .clk(clk), .rst_n(rst_n), .wr_en_i(in2_wr_en), .data_i(in2_data_in), .rd_en_i(issue),
    .data_o(b_data), .empty_o(in2_empty), .full_o(in2_full)
  );
  hsi_vec_alu #(.W(COMPONENT_WIDTH), .FRAC_BITS(FRAC_BITS)) u_alu (
    .clk(clk), .rst_n(rst_n), .issue_i(issue), .op_i(hsi_op_t'(op_code[1:0])),
    .a_i(a_data), .b_i(b_data), .valid_o(out_wr_en), .data_o(alu_data), .ovf_o(alu_ovf), .busy_o(busy)
  );
  fifo_cache #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_out (
    .clk(clk), .rst_n(rst_n), .wr_en_i(out_wr_en), .data_i(alu_data), .rd_en_i(out_rd_en),
    .data_o(out_data_out), .empty_o(out_empty), .full_o(out_full)
  );
  assign ovf_flag = ovf_q;
  assign result_count = cnt_q;
endmodule

// File: tb/tb_hsi_vector_unit.sv
// tb_hsi_vector_unit: directed and randomized checks of hsi_vector_unit against an arithmetic model
module tb_hsi_vector_unit;
  localparam int W = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in1_wr_en = 1'b0, in2_wr_en = 1'b0, out_rd_en = 1'b0, ovf_clr = 1'b0;
  logic [47:0] in1_data_in = '0, in2_data_in = '0;
  logic [1:0] op_code = 2'd0;
  logic in1_full, in2_full, out_empty, out_full, ovf_flag, busy;
  logic [47:0] out_data_out;
  logic [15:0] result_count;
  int checks = 0;
  int failures = 0;
  int n_res = 0;
  bit exp_ovf = 1'b0;
  logic [47:0] exp_q [$];

  always #5 clk = ~clk;

  hsi_vector_unit #(.COMPONENT_WIDTH(W), .FIFO_DEPTH(DEPTH), .OPC_WIDTH(2), .FRAC_BITS(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1_wr_en(in1_wr_en), .in1_data_in(in1_data_in), .in1_full(in1_full),
    .in2_wr_en(in2_wr_en), .in2_data_in(in2_data_in), .in2_full(in2_full),
    .out_rd_en(out_rd_en), .out_data_out(out_data_out), .out_empty(out_empty), .out_full(out_full),
    .op_code(op_code), .ovf_clr(ovf_clr), .ovf_flag(ovf_flag), .busy(busy), .result_count(result_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] v3(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  function automatic logic [47:0] rnd();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  // Reference: exact integer arithmetic, then range check and clamp or wrap to 16 bits.
  function automatic logic [47:0] model(input int op, input logic [47:0] a, input logic [47:0] b, output bit ov);
    longint x [3];
    longint y [3];
    longint r [3];
    logic [47:0] res;
    for (int i = 0; i < 3; i++) begin
      x[i] = longint'($signed(a[47-16*i -: 16]));
      y[i] = longint'($signed(b[47-16*i -: 16]));
    end
    case (op)
      0: for (int i = 0; i < 3; i++) r[i] = x[i] + y[i];
      1: begin
        r[0] = x[1] * y[2] - x[2] * y[1];
        r[1] = x[2] * y[0] - x[0] * y[2];
        r[2] = x[0] * y[1] - x[1] * y[0];
      end
      2: begin
        r[0] = x[0] * y[0] + x[1] * y[1] + x[2] * y[2];
        r[1] = 0;
        r[2] = 0;
      end
      default: for (int i = 0; i < 3; i++) r[i] = x[i] - y[i];
    endcase
    ov = 1'b0;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      if (r[i] > 32767 || r[i] < -32768) begin
        ov = 1'b1;
`ifdef HSI_VECTOR_UNIT_SAT_EN
        r[i] = r[i] > 0 ? 32767 : -32768;
`endif
      end
      res[47-16*i -: 16] = 16'(r[i]);
    end
    return res;
  endfunction

  // One clock; any pop that happened on this edge is checked against the scoreboard.
  task automatic tick();
    bit pend;
    pend = out_rd_en && !out_empty;
    @(negedge clk);
    if (pend) begin
      chk("pop_avail", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("pop_data", 64'(out_data_out), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic push(input logic [47:0] a, input logic [47:0] b, input logic [47:0] e, input bit ov);
    in1_wr_en = 1'b1;
    in2_wr_en = 1'b1;
    in1_data_in = a;
    in2_data_in = b;
    exp_q.push_back(e);
    exp_ovf |= ov;
    n_res++;
    tick();
    in1_wr_en = 1'b0;
    in2_wr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_rd_en = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    out_rd_en = 1'b0;
    tick();
    chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_count"}, 64'(result_count), 64'(16'(n_res)));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic fill_six(input string tag);
    logic [47:0] a, b, e;
    bit ov;
    op_code = 2'd0;
    for (int i = 0; i < 6; i++) begin
      a = {16'($urandom_range(0, 999)), 16'($urandom_range(0, 999)), 16'($urandom_range(0, 999))};
      b = {16'($urandom_range(0, 999)), 16'($urandom_range(0, 999)), 16'($urandom_range(0, 999))};
      e = model(0, a, b, ov);
      push(a, b, e, ov);
    end
    repeat (10) tick();
    chk({tag, "_full"}, 64'(out_full), 64'(1));
    chk({tag, "_stall_count"}, 64'(result_count), 64'(16'(n_res - 2)));
    drain(tag);
  endtask

  initial begin
    logic [47:0] a, b, e;
    bit ov;
    int op, k;
    repeat (3) @(negedge clk);
    chk("rst_out_empty", 64'(out_empty), 64'(1));
    chk("rst_out_full", 64'(out_full), 64'(0));
    chk("rst_in1_full", 64'(in1_full), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(result_count), 64'(0));
    chk("rst_ovf", 64'(ovf_flag), 64'(0));
    rst_n = 1'b1;
    tick();
    // CROSS latency: push at P0, issue captured P1, write lands on P4
    op_code = 2'd1;
    push(v3(1, 2, 3), v3(4, 5, 6), v3(-3, 6, -3), 1'b0);
    repeat (3) tick();
    chk("cross_not_yet", 64'(out_empty), 64'(1));
    chk("cross_busy", 64'(busy), 64'(1));
    tick();
    chk("cross_written", 64'(out_empty), 64'(0));
    chk("cross_count", 64'(result_count), 64'(1));
    drain("cross");
    // Per-issue op change, back-to-back
    push(v3(1, 2, 3), v3(4, 5, 6), v3(32, 0, 0), 1'b0);
    op_code = 2'd2;
    push(v3(1, 2, 3), v3(4, 5, 6), v3(5, 7, 9), 1'b0);
    op_code = 2'd0;
    push(v3(1, 2, 3), v3(4, 5, 6), v3(-3, -3, -3), 1'b0);
    op_code = 2'd3;
    tick();
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("b2b_count", 64'(result_count), 64'(i));
    end
    drain("mixed");
    // Overflow, clear, and set-beats-clear
    op_code = 2'd0;
    chk("ovf_pre", 64'(ovf_flag), 64'(0));
`ifdef HSI_VECTOR_UNIT_SAT_EN
    e = v3(32767, 0, 0);
`else
    e = v3(-32768, 0, 0);
`endif
    push(v3(32767, 0, 0), v3(1, 0, 0), e, 1'b1);
    repeat (3) tick();
    chk("ovf_before_write", 64'(ovf_flag), 64'(0));
    tick();
    chk("ovf_set", 64'(ovf_flag), 64'(1));
    drain("ovf");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 64'(ovf_flag), 64'(0));
    push(v3(32767, 0, 0), v3(1, 0, 0), e, 1'b1);
    repeat (3) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 64'(ovf_flag), 64'(1));
    drain("ovf2");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    // Credit backpressure, then reads on an empty output FIFO must not mint credits
    fill_six("bp1");
    out_rd_en = 1'b1;
    repeat (3) tick();
    out_rd_en = 1'b0;
    tick();
    fill_six("bp2");
    // Randomized groups, one op per group
    for (int g = 0; g < 20; g++) begin
      op = int'($urandom_range(0, 3));
      op_code = 2'(op);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      k = int'($urandom_range(1, 4));
      for (int i = 0; i < k; i++) begin
        a = rnd();
        b = rnd();
        e = model(op, a, b, ov);
        push(a, b, e, ov);
      end
      drain("rand");
      chk("rand_ovf", 64'(ovf_flag), 64'(exp_ovf));
    end
    // Asynchronous reset with work in flight
    op_code = 2'd1;
    for (int i = 0; i < 3; i++) begin
      a = rnd();
      b = rnd();
      e = model(1, a, b, ov);
      push(a, b, e, ov);
    end
    chk("inflight_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_empty", 64'(out_empty), 64'(1));
    chk("arst_count", 64'(result_count), 64'(0));
    exp_q.delete();
    n_res = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(v3(1, 2, 3), v3(4, 5, 6), v3(-3, 6, -3), 1'b0);
    drain("post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
